// File: rtl/sqrt_approx_ctrl.sv
// sqrt_approx_ctrl: sequencing FSM for the sqrt(a^2+b^2) approximation datapath.
// Walks LOAD, ABSA, ABSB, MAX, MIN, SUB, ADD, FMAX and ends in DONE. Each compute
// state is held AU_LAT+1 cycles. Register enables pulse only in the final cycle.
// All outputs are registered. They are decoded from the next state and the next
// wait count, so they change on the same edge as the state register.
// Optional feature macro: SQRT_CTRL_ABORT_EN adds an `abort` input. When abort is
// high in any state other than IDLE, the FSM returns to IDLE on the next cycle.
module sqrt_approx_ctrl #(
  parameter int AU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef SQRT_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       en_R1,
  output logic       en_R2,
  output logic       en_R3,
  output logic       en_R4,
  output logic       en_R5,
  output logic       b1,
  output logic       b6,
  output logic [1:0] b2,
  output logic [1:0] b3,
  output logic [1:0] b4,
  output logic [1:0] b5,
  output logic [1:0] b7,
  output logic [1:0] sel_AU1,
  output logic [1:0] sel_AU2,
  output logic       Done
);

  localparam int CW = (AU_LAT < 1) ? 1 : $clog2(AU_LAT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(AU_LAT);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_LOAD = 4'd1, S_ABSA = 4'd2, S_ABSB = 4'd3, S_MAX = 4'd4,
    S_MIN  = 4'd5, S_SUB  = 4'd6, S_ADD  = 4'd7, S_FMAX = 4'd8, S_DONE = 4'd9
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       en_r1, en_r2, en_r3, en_r4, en_r5;
    logic       b1, b6;
    logic [1:0] b2, b3, b4, b5, b7;
    logic [1:0] sel_au1, sel_au2;
    logic       done;
  } ctrl_t;

  state_t        state_r, state_nat_s, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nat_s, cnt_nxt_s;
  ctrl_t         ctrl_r;

  // Successor of each compute state once its wait has elapsed.
  function automatic state_t succ(input state_t st);
    state_t n;
    case (st)
      S_ABSA:  n = S_ABSB;
      S_ABSB:  n = S_MAX;
      S_MAX:   n = S_MIN;
      S_MIN:   n = S_SUB;
      S_SUB:   n = S_ADD;
      S_ADD:   n = S_FMAX;
      S_FMAX:  n = S_DONE;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  // Output decode: selects are held for the whole state, enables only on the last wait cycle.
  function automatic ctrl_t decode(input state_t st, input logic [CW-1:0] cnt);
    ctrl_t c;
    logic  last_s;
    c      = '0;
    last_s = (cnt == LAST_CNT);
    case (st)
      S_LOAD: begin
        c.busy = 1'b1; c.b3 = 2'b10; c.b4 = 2'b10; c.en_r1 = 1'b1; c.en_r2 = 1'b1;
      end
      S_ABSA: begin
        c.busy = 1'b1; c.b1 = 1'b1; c.b3 = 2'b01; c.sel_au1 = 2'b00;
      end
      S_ABSB: begin
        c.busy = 1'b1; c.b2 = 2'b01; c.b4 = 2'b01; c.sel_au1 = 2'b01;
      end
      S_MAX: begin
        c.busy = 1'b1; c.b1 = 1'b1; c.b2 = 2'b01; c.sel_au1 = 2'b11; c.b7 = 2'b10;
        c.en_r4 = last_s; c.en_r3 = last_s;
      end
      S_MIN: begin
        c.busy = 1'b1; c.b1 = 1'b1; c.b2 = 2'b01; c.sel_au1 = 2'b10; c.en_r5 = last_s;
      end
      S_SUB: begin
        c.busy = 1'b1; c.b5 = 2'b10; c.b7 = 2'b01; c.sel_au2 = 2'b00; c.en_r3 = last_s;
      end
      S_ADD: begin
        c.busy = 1'b1; c.b5 = 2'b01; c.b7 = 2'b01; c.sel_au2 = 2'b01; c.en_r3 = last_s;
      end
      S_FMAX: begin
        c.busy = 1'b1; c.b5 = 2'b10; c.b7 = 2'b01; c.sel_au2 = 2'b10; c.en_r3 = last_s;
      end
      S_DONE:  c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Natural sequencing: start handshake, wait counting and state advance.
  always_comb begin
    state_nat_s = state_r;
    cnt_nat_s   = cnt_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nat_s = S_LOAD;
          cnt_nat_s   = '0;
        end else begin
          state_nat_s = state_r;
          cnt_nat_s   = '0;
        end
      end
      S_LOAD: begin
        state_nat_s = S_ABSA;
        cnt_nat_s   = '0;
      end
      S_ABSA, S_ABSB, S_MAX, S_MIN, S_SUB, S_ADD, S_FMAX: begin
        if (cnt_r == LAST_CNT) begin
          state_nat_s = succ(state_r);
          cnt_nat_s   = '0;
        end else begin
          state_nat_s = state_r;
          cnt_nat_s   = cnt_r + CW'(1'b1);
        end
      end
      default: begin
        state_nat_s = S_IDLE;
        cnt_nat_s   = '0;
      end
    endcase
  end

  // Abort override (when built in); abort beats start, rst beats both.
  always_comb begin
    state_nxt_s = state_nat_s;
    cnt_nxt_s   = cnt_nat_s;
`ifdef SQRT_CTRL_ABORT_EN
    if (abort && (state_r != S_IDLE)) begin
      state_nxt_s = S_IDLE;
      cnt_nxt_s   = '0;
    end else begin
      state_nxt_s = state_nat_s;
      cnt_nxt_s   = cnt_nat_s;
    end
`endif
  end

  // State, wait counter and registered output decode with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      ctrl_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ctrl_r  <= decode(state_nxt_s, cnt_nxt_s);
    end
  end

  assign busy    = ctrl_r.busy;
  assign en_R1   = ctrl_r.en_r1;
  assign en_R2   = ctrl_r.en_r2;
  assign en_R3   = ctrl_r.en_r3;
  assign en_R4   = ctrl_r.en_r4;
  assign en_R5   = ctrl_r.en_r5;
  assign b1      = ctrl_r.b1;
  assign b6      = ctrl_r.b6;
  assign b2      = ctrl_r.b2;
  assign b3      = ctrl_r.b3;
  assign b4      = ctrl_r.b4;
  assign b5      = ctrl_r.b5;
  assign b7      = ctrl_r.b7;
  assign sel_AU1 = ctrl_r.sel_au1;
  assign sel_AU2 = ctrl_r.sel_au2;
  assign Done    = ctrl_r.done;

endmodule

// File: tb/tb_sqrt_approx_ctrl.sv
// Testbench for sqrt_approx_ctrl. The reference model tracks the operation as a
// phase (idle / in-op / done) and a cycle index within the op. It derives the
// expected control word from that index with plain arithmetic.
module tb_sqrt_approx_ctrl;

  localparam int L     = 1;
  localparam int OPLEN = 1 + 7 * (L + 1);

  logic clk = 1'b0;
  logic rst, start, abort_v;
  logic busy, en_R1, en_R2, en_R3, en_R4, en_R5, b1, b6, Done;
  logic [1:0] b2, b3, b4, b5, b7, sel_AU1, sel_AU2;

  int checks = 0;
  int errors = 0;
  int phase  = 0;   // 0 idle, 1 in op, 2 done
  int k      = 0;   // cycle index inside the op (0 = LOAD)

  typedef struct packed {
    logic       busy, en1, en2, en3, en4, en5, b1, b6;
    logic [1:0] b2, b3, b4, b5, b7, au1, au2;
    logic       done;
  } exp_t;

  always #5 clk = ~clk;

  sqrt_approx_ctrl #(.AU_LAT(L)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SQRT_CTRL_ABORT_EN
    .abort(abort_v),
`endif
    .busy(busy), .en_R1(en_R1), .en_R2(en_R2), .en_R3(en_R3), .en_R4(en_R4), .en_R5(en_R5),
    .b1(b1), .b6(b6), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b7(b7),
    .sel_AU1(sel_AU1), .sel_AU2(sel_AU2), .Done(Done)
  );

  function automatic exp_t expected();
    exp_t e;
    int   s;
    logic last;
    e = '0;
    if (phase == 2) begin
      e.done = 1'b1;
    end else if (phase == 1 && k == 0) begin
      e.busy = 1'b1; e.b3 = 2'b10; e.b4 = 2'b10; e.en1 = 1'b1; e.en2 = 1'b1;
    end else if (phase == 1) begin
      s    = (k - 1) / (L + 1);
      last = (((k - 1) % (L + 1)) == L);
      e.busy = 1'b1;
      case (s)
        0: begin e.b1 = 1'b1; e.b3 = 2'b01; e.au1 = 2'b00; end
        1: begin e.b2 = 2'b01; e.b4 = 2'b01; e.au1 = 2'b01; end
        2: begin e.b1 = 1'b1; e.b2 = 2'b01; e.au1 = 2'b11; e.b7 = 2'b10; e.en4 = last; e.en3 = last; end
        3: begin e.b1 = 1'b1; e.b2 = 2'b01; e.au1 = 2'b10; e.en5 = last; end
        4: begin e.b5 = 2'b10; e.b7 = 2'b01; e.au2 = 2'b00; e.en3 = last; end
        5: begin e.b5 = 2'b01; e.b7 = 2'b01; e.au2 = 2'b01; e.en3 = last; end
        6: begin e.b5 = 2'b10; e.b7 = 2'b01; e.au2 = 2'b10; e.en3 = last; end
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b, expected %b (t=%0t, phase=%0d, k=%0d)", tag, obs, exp, $time, phase, k);
    end
  endtask

  task automatic check_all();
    exp_t e;
    logic bus_ok;
    e = expected();
    check("busy",  {1'b0, busy},  {1'b0, e.busy});
    check("en_R1", {1'b0, en_R1}, {1'b0, e.en1});
    check("en_R2", {1'b0, en_R2}, {1'b0, e.en2});
    check("en_R3", {1'b0, en_R3}, {1'b0, e.en3});
    check("en_R4", {1'b0, en_R4}, {1'b0, e.en4});
    check("en_R5", {1'b0, en_R5}, {1'b0, e.en5});
    check("b1",    {1'b0, b1},    {1'b0, e.b1});
    check("b6",    {1'b0, b6},    2'b00);
    check("b2", b2, e.b2);
    check("b3", b3, e.b3);
    check("b4", b4, e.b4);
    check("b5", b5, e.b5);
    check("b7", b7, e.b7);
    check("sel_AU1", sel_AU1, e.au1);
    check("sel_AU2", sel_AU2, e.au2);
    check("Done",  {1'b0, Done},  {1'b0, e.done});
    bus_ok = (b2 != 2'b11) && (b3 != 2'b11) && (b4 != 2'b11) && (b5 != 2'b11) && (b7 != 2'b11);
    check("bus_not_11", {1'b0, bus_ok}, 2'b01);
  endtask

  task automatic model_update();
    if (rst) begin
      phase = 0;
    end else if (abort_v && phase != 0) begin
      phase = 0;
    end else if (phase == 1) begin
      if (k == OPLEN - 1) phase = 2;
      else k = k + 1;
    end else if (start) begin
      phase = 1;
      k     = 0;
    end
  endtask

  // One clock: edge, model advance, then sample the DUT 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  // Launch one op and measure the cycle in which Done first rises.
  task automatic run_op(input int pulse_a, input int pulse_b);
    int e_cnt;
    start = 1'b1;
    step();
    e_cnt = 0;
    while (Done !== 1'b1 && e_cnt < 100) begin
      e_cnt++;
      start = (e_cnt == pulse_a || e_cnt == pulse_b) ? 1'b1 : 1'b0;
      step();
    end
    start = 1'b0;
    check("done_latency", 2'(((e_cnt + 1) == 2 + 7 * (L + 1)) ? 1 : 0), 2'b01);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort_v = 1'b0;
    // Reset for two cycles, then idle.
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Single op; Done must rise in cycle 2+7*(L+1).
    run_op(-1, -1);
    for (int i = 0; i < 3; i++) step();

    // start pulses inside ABSB (k=3) and ADD (k=11) are ignored.
    run_op(4, 12);
    step();

    // start held high: LOAD directly after every DONE.
    start = 1'b1;
    for (int i = 0; i < 3 * (OPLEN + 1); i++) step();
    start = 1'b0;
    step(); step();

    // rst during SUB aborts the op.
    start = 1'b1; step(); start = 1'b0;
    while (k != 9) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_in_sub_idle", 2'(phase), 2'd0);
    step(); step();

`ifdef SQRT_CTRL_ABORT_EN
    // abort in MIN returns to IDLE.
    start = 1'b1; step(); start = 1'b0;
    while (k != 7) step();
    abort_v = 1'b1; step(); abort_v = 1'b0;
    step();
    // abort together with start in DONE returns to IDLE.
    run_op(-1, -1);
    abort_v = 1'b1; start = 1'b1; step();
    abort_v = 1'b0; start = 1'b0;
    step(); step();
`endif

    // Random traffic checked against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
      rst   = ($urandom_range(0, 90) == 0) ? 1'b1 : 1'b0;
`ifdef SQRT_CTRL_ABORT_EN
      abort_v = ($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0;
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
